// File: rtl/decode_queue_pkg.sv
// Shared types and constants for the RV32I(+M) decode queue.
package decode_queue_pkg;

  localparam int unsigned OP_ENUM_W = 6;

  // Decoded operation; OP_RESET doubles as the "no valid operation" marker
  typedef enum logic [OP_ENUM_W-1:0] {
    OP_RESET = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  // One queue entry: {op, rd, rs1, rs2, imm, pc, flags}
  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        is_jump;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } dec_entry_t;

  localparam int unsigned DEC_ENTRY_W = $bits(dec_entry_t);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct7 classes
  localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the decode queue.
interface decode_queue_if;
  logic                   in_valid;
  logic [31:0]            in_inst;
  logic [31:0]            in_pc;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  decode_queue_pkg::op_e  out_op_enum;
  logic [4:0]             out_rd;
  logic [4:0]             out_rs1;
  logic [4:0]             out_rs2;
  logic [31:0]            out_imm;
  logic [31:0]            out_pc;
  logic                   out_is_jump;
  logic                   out_is_load;
  logic                   out_is_store;
  logic                   out_illegal;

  // Environment side: fetch producer and dispatcher consumer
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_op_enum, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_is_jump, out_is_load, out_is_store, out_illegal
  );

  // Queue side
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_op_enum, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_is_jump, out_is_load, out_is_store, out_illegal
  );
endinterface

// File: rtl/decode_queue_rv32_decode_core.sv
// Pure combinational RV32I(+M) decoder producing one queue entry.
module rv32_decode_core
  import decode_queue_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output dec_entry_t  entry
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;

  assign opcode = inst[6:0];
  assign rd_f   = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // Shift amount only; the upper immediate bits are funct7, not part of the value
  assign imm_sh = {27'b0, inst[24:20]};

  dec_entry_t raw;
  logic       legal;

  // Classify the instruction and fill operand fields by format
  always_comb begin
    raw   = '0;
    legal = 1'b1;
    unique case (opcode)
      OPC_LUI: begin
        raw.op = OP_LUI; raw.rd = rd_f; raw.imm = imm_u;
      end
      OPC_AUIPC: begin
        raw.op = OP_AUIPC; raw.rd = rd_f; raw.imm = imm_u;
      end
      OPC_JAL: begin
        raw.op = OP_JAL; raw.rd = rd_f; raw.imm = imm_j; raw.is_jump = 1'b1;
      end
      OPC_JALR: begin
        raw.op = OP_JALR; raw.rd = rd_f; raw.rs1 = rs1_f; raw.imm = imm_i;
        raw.is_jump = 1'b1;
        legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        raw.rs1 = rs1_f; raw.rs2 = rs2_f; raw.imm = imm_b; raw.is_jump = 1'b1;
        case (funct3)
          3'b000:  raw.op = OP_BEQ;
          3'b001:  raw.op = OP_BNE;
          3'b100:  raw.op = OP_BLT;
          3'b101:  raw.op = OP_BGE;
          3'b110:  raw.op = OP_BLTU;
          3'b111:  raw.op = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        raw.rd = rd_f; raw.rs1 = rs1_f; raw.imm = imm_i; raw.is_load = 1'b1;
        case (funct3)
          3'b000:  raw.op = OP_LB;
          3'b001:  raw.op = OP_LH;
          3'b010:  raw.op = OP_LW;
          3'b100:  raw.op = OP_LBU;
          3'b101:  raw.op = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        raw.rs1 = rs1_f; raw.rs2 = rs2_f; raw.imm = imm_s; raw.is_store = 1'b1;
        case (funct3)
          3'b000:  raw.op = OP_SB;
          3'b001:  raw.op = OP_SH;
          3'b010:  raw.op = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        raw.rd = rd_f; raw.rs1 = rs1_f; raw.imm = imm_i;
        case (funct3)
          3'b000: raw.op = OP_ADDI;
          3'b010: raw.op = OP_SLTI;
          3'b011: raw.op = OP_SLTIU;
          3'b100: raw.op = OP_XORI;
          3'b110: raw.op = OP_ORI;
          3'b111: raw.op = OP_ANDI;
          3'b001: begin
            raw.op  = OP_SLLI;
            raw.imm = imm_sh;
            legal   = (funct7 == FUNC7_BASE);
          end
          default: begin
            raw.imm = imm_sh;
            if (funct7 == FUNC7_BASE)     raw.op = OP_SRLI;
            else if (funct7 == FUNC7_ALT) raw.op = OP_SRAI;
            else                          legal  = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        raw.rd = rd_f; raw.rs1 = rs1_f; raw.rs2 = rs2_f;
        case (funct7)
          FUNC7_BASE: begin
            case (funct3)
              3'b000:  raw.op = OP_ADD;
              3'b001:  raw.op = OP_SLL;
              3'b010:  raw.op = OP_SLT;
              3'b011:  raw.op = OP_SLTU;
              3'b100:  raw.op = OP_XOR;
              3'b101:  raw.op = OP_SRL;
              3'b110:  raw.op = OP_OR;
              default: raw.op = OP_AND;
            endcase
          end
          FUNC7_ALT: begin
            case (funct3)
              3'b000:  raw.op = OP_SUB;
              3'b101:  raw.op = OP_SRA;
              default: legal = 1'b0;
            endcase
          end
          FUNC7_MULDIV: begin
            if (ENABLE_M) begin
              case (funct3)
                3'b000:  raw.op = OP_MUL;
                3'b001:  raw.op = OP_MULH;
                3'b010:  raw.op = OP_MULHSU;
                3'b011:  raw.op = OP_MULHU;
                3'b100:  raw.op = OP_DIV;
                3'b101:  raw.op = OP_DIVU;
                3'b110:  raw.op = OP_REM;
                default: raw.op = OP_REMU;
              endcase
            end else begin
              legal = 1'b0;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings keep only their PC and the illegal flag
  always_comb begin
    entry    = raw;
    entry.pc = pc;
    if (!legal) begin
      entry         = '0;
      entry.pc      = pc;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes fetched instructions into a FIFO and
// presents the head entry to the dispatcher.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  decode_queue_if.slave   bus,
  output logic [ADDR_W:0] count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  dec_entry_t        dec_entry;
  dec_entry_t        head;
  dec_entry_t        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  rv32_decode_core #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .inst  (bus.in_inst),
    .pc    (bus.in_pc),
    .entry (dec_entry)
  );

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid & ~full & rdy_in & ~flush_in;
  assign pop   = ~empty & bus.out_ready & rdy_in & ~flush_in;

  // Occupancy and pointer state; flush overrides any same-cycle push/pop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= dec_entry;
  end

  // Head entry, forced to zero while the queue is empty
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign bus.in_ready     = ~full;
  assign bus.out_valid    = ~empty;
  assign bus.out_op_enum  = head.op;
  assign bus.out_rd       = head.rd;
  assign bus.out_rs1      = head.rs1;
  assign bus.out_rs2      = head.rs2;
  assign bus.out_imm      = head.imm;
  assign bus.out_pc       = head.pc;
  assign bus.out_is_jump  = head.is_jump;
  assign bus.out_is_load  = head.is_load;
  assign bus.out_is_store = head.is_store;
  assign bus.out_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: two instances (M off / M on) share
// one stimulus stream and are compared against a table-driven reference.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       flush;
  logic [3:0] count;
  logic [3:0] count_m;

  decode_queue_if dq ();
  decode_queue_if dq_m ();

  assign dq_m.in_valid  = dq.in_valid;
  assign dq_m.in_inst   = dq.in_inst;
  assign dq_m.in_pc     = dq.in_pc;
  assign dq_m.out_ready = dq.out_ready;

  decode_queue #(.DEPTH(8), .ADDR_W(3), .ENABLE_M(1'b0)) u_dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .bus(dq.slave), .count(count)
  );
  decode_queue #(.DEPTH(8), .ADDR_W(3), .ENABLE_M(1'b1)) u_dut_m (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .bus(dq_m.slave), .count(count_m)
  );

  always #5 clk = ~clk;

  dec_entry_t obs, obs_m;
  assign obs   = {dq.out_op_enum, dq.out_rd, dq.out_rs1, dq.out_rs2, dq.out_imm, dq.out_pc,
                  dq.out_is_jump, dq.out_is_load, dq.out_is_store, dq.out_illegal};
  assign obs_m = {dq_m.out_op_enum, dq_m.out_rd, dq_m.out_rs1, dq_m.out_rs2, dq_m.out_imm, dq_m.out_pc,
                  dq_m.out_is_jump, dq_m.out_is_load, dq_m.out_is_store, dq_m.out_illegal};

  // Reference: instruction formats and a mask/match pattern table
  typedef enum logic [3:0] {F_U, F_J, F_JR, F_B, F_L, F_S, F_I, F_SH, F_R} fmt_e;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    op_e         op;
    fmt_e        fmt;
    bit          m_ext;
  } pat_t;

  pat_t       pats[$];
  dec_entry_t mq[$];
  dec_entry_t mq_m[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [31:0] pc_ctr = 32'h0;

  localparam logic [31:0] M_OPC = 32'h0000_007F;
  localparam logic [31:0] M_F3  = 32'h0000_707F;
  localparam logic [31:0] M_F7  = 32'hFE00_707F;

  function automatic logic [31:0] enc(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
    return {f7, 10'b0, f3, 5'b0, opc};
  endfunction

  function automatic void add(logic [31:0] mask, logic [31:0] match, op_e op, fmt_e fmt, bit m = 1'b0);
    pat_t p;
    p.mask = mask; p.match = match; p.op = op; p.fmt = fmt; p.m_ext = m;
    pats.push_back(p);
  endfunction

  function automatic void build_table();
    op_e r_ops[8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    op_e m_ops[8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    add(M_OPC, 32'h37, OP_LUI, F_U);
    add(M_OPC, 32'h17, OP_AUIPC, F_U);
    add(M_OPC, 32'h6F, OP_JAL, F_J);
    add(M_F3, enc(0, 0, 7'h67), OP_JALR, F_JR);
    add(M_F3, enc(0, 0, 7'h63), OP_BEQ, F_B);
    add(M_F3, enc(0, 1, 7'h63), OP_BNE, F_B);
    add(M_F3, enc(0, 4, 7'h63), OP_BLT, F_B);
    add(M_F3, enc(0, 5, 7'h63), OP_BGE, F_B);
    add(M_F3, enc(0, 6, 7'h63), OP_BLTU, F_B);
    add(M_F3, enc(0, 7, 7'h63), OP_BGEU, F_B);
    add(M_F3, enc(0, 0, 7'h03), OP_LB, F_L);
    add(M_F3, enc(0, 1, 7'h03), OP_LH, F_L);
    add(M_F3, enc(0, 2, 7'h03), OP_LW, F_L);
    add(M_F3, enc(0, 4, 7'h03), OP_LBU, F_L);
    add(M_F3, enc(0, 5, 7'h03), OP_LHU, F_L);
    add(M_F3, enc(0, 0, 7'h23), OP_SB, F_S);
    add(M_F3, enc(0, 1, 7'h23), OP_SH, F_S);
    add(M_F3, enc(0, 2, 7'h23), OP_SW, F_S);
    add(M_F3, enc(0, 0, 7'h13), OP_ADDI, F_I);
    add(M_F3, enc(0, 2, 7'h13), OP_SLTI, F_I);
    add(M_F3, enc(0, 3, 7'h13), OP_SLTIU, F_I);
    add(M_F3, enc(0, 4, 7'h13), OP_XORI, F_I);
    add(M_F3, enc(0, 6, 7'h13), OP_ORI, F_I);
    add(M_F3, enc(0, 7, 7'h13), OP_ANDI, F_I);
    add(M_F7, enc(7'h00, 1, 7'h13), OP_SLLI, F_SH);
    add(M_F7, enc(7'h00, 5, 7'h13), OP_SRLI, F_SH);
    add(M_F7, enc(7'h20, 5, 7'h13), OP_SRAI, F_SH);
    add(M_F7, enc(7'h20, 0, 7'h33), OP_SUB, F_R);
    add(M_F7, enc(7'h20, 5, 7'h33), OP_SRA, F_R);
    for (int unsigned f = 0; f < 8; f++) begin
      add(M_F7, enc(7'h00, f[2:0], 7'h33), r_ops[f], F_R);
      add(M_F7, enc(7'h01, f[2:0], 7'h33), m_ops[f], F_R, 1'b1);
    end
  endfunction

  // Sign-extend the low 'bits' bits of v by plain arithmetic
  function automatic logic [31:0] sx(logic [31:0] v, int unsigned bits);
    return v[bits-1] ? v - (32'd1 << bits) : v;
  endfunction

  function automatic dec_entry_t ref_decode(logic [31:0] inst, logic [31:0] pc, bit en_m);
    dec_entry_t e;
    fmt_e       fmt;
    int         idx = -1;
    foreach (pats[i])
      if (idx < 0 && (inst & pats[i].mask) == pats[i].match && (en_m || !pats[i].m_ext)) idx = i;
    e    = '0;
    e.pc = pc;
    if (idx < 0) begin
      e.illegal = 1'b1;
      return e;
    end
    fmt  = pats[idx].fmt;
    e.op = pats[idx].op;
    e.rd  = (fmt inside {F_B, F_S}) ? 5'd0 : inst[11:7];
    e.rs1 = (fmt inside {F_U, F_J}) ? 5'd0 : inst[19:15];
    e.rs2 = (fmt inside {F_B, F_S, F_R}) ? inst[24:20] : 5'd0;
    case (fmt)
      F_U:            e.imm = inst & 32'hFFFF_F000;
      F_J:            e.imm = sx({11'b0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
      F_B:            e.imm = sx({19'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
      F_S:            e.imm = sx({20'b0, inst[31:25], inst[11:7]}, 12);
      F_I, F_L, F_JR: e.imm = sx({20'b0, inst[31:20]}, 12);
      F_SH:           e.imm = {27'b0, inst[24:20]};
      default:        e.imm = 32'd0;
    endcase
    e.is_jump  = fmt inside {F_J, F_JR, F_B};
    e.is_load  = (fmt == F_L);
    e.is_store = (fmt == F_S);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    int unsigned k = $urandom_range(0, 9);
    pat_t        p = pats[$urandom_range(0, pats.size() - 1)];
    logic [31:0] base = p.match | ($urandom & ~p.mask);
    if (k == 0) return $urandom;
    if (k == 1) return base ^ (32'h1 << $urandom_range(12, 31));
    return base;
  endfunction

  function automatic dec_entry_t head_of(bit m);
    dec_entry_t e = '0;
    if (m && mq_m.size() > 0) e = mq_m[0];
    if (!m && mq.size() > 0) e = mq[0];
    return e;
  endfunction

  task automatic chk(string tag, logic [127:0] observed, logic [127:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".count"}, {count, count_m}, {4'(mq.size()), 4'(mq_m.size())});
    chk({tag, ".handshake"}, {dq.in_ready, dq.out_valid, dq_m.in_ready, dq_m.out_valid},
        {mq.size() != DEPTH, mq.size() != 0, mq_m.size() != DEPTH, mq_m.size() != 0});
    chk({tag, ".head"}, obs, head_of(1'b0));
    chk({tag, ".head_m"}, obs_m, head_of(1'b1));
  endtask

  // One clock: predict queue effects from the inputs held across the edge
  task automatic tick();
    bit         push, pop;
    dec_entry_t e, em;
    push = dq.in_valid && mq.size() < DEPTH && rdy && !flush;
    pop  = dq.out_ready && mq.size() > 0 && rdy && !flush;
    e    = ref_decode(dq.in_inst, dq.in_pc, 1'b0);
    em   = ref_decode(dq.in_inst, dq.in_pc, 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (rdy && flush) begin
      mq.delete();
      mq_m.delete();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        void'(mq_m.pop_front());
      end
      if (push) begin
        mq.push_back(e);
        mq_m.push_back(em);
      end
    end
  endtask

  task automatic drive(bit v, logic [31:0] inst, bit ordy);
    dq.in_valid  = v;
    dq.in_inst   = inst;
    dq.in_pc     = pc_ctr;
    dq.out_ready = ordy;
    pc_ctr       = pc_ctr + 32'd4;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    dq.in_valid = 1'b0; dq.in_inst = '0; dq.in_pc = '0; dq.out_ready = 1'b0;
    build_table();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset");

    // ADDI x1, x0, 5 at pc 0
    drive(1'b1, 32'h0050_0093, 1'b0);
    tick();
    check_all("addi");
    chk("addi.direct", {dq.out_valid, dq.out_op_enum, dq.out_rd, dq.out_rs1, dq.out_rs2, dq.out_imm, dq.out_pc},
        {1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0});

    // srai, srli, mul pushed while popping the previous head
    drive(1'b1, 32'h4021_5193, 1'b1);
    tick();
    check_all("srai");
    chk("srai.direct", {dq.out_op_enum, dq.out_rd, dq.out_rs1, dq.out_imm, dq.out_illegal},
        {OP_SRAI, 5'd3, 5'd2, 32'd2, 1'b0});
    drive(1'b1, 32'h0021_5193, 1'b1);
    tick();
    check_all("srli");
    chk("srli.direct", {dq.out_op_enum, dq.out_imm, dq.out_illegal}, {OP_SRLI, 32'd2, 1'b0});
    drive(1'b1, 32'h0273_02B3, 1'b1);
    tick();
    check_all("mul");
    chk("mul.noM", {dq.out_illegal, dq.out_op_enum}, {1'b1, OP_RESET});
    chk("mul.withM", {dq_m.out_illegal, dq_m.out_op_enum, dq_m.out_rd, dq_m.out_rs1, dq_m.out_rs2},
        {1'b0, OP_MUL, 5'd5, 5'd6, 5'd7});
    drive(1'b0, '0, 1'b1);
    tick();
    check_all("drain_mul");

    // Fill with dispatcher stalled; the 9th offer must be refused
    for (int unsigned i = 0; i < 9; i++) begin
      drive(1'b1, rand_inst(), 1'b0);
      tick();
      check_all("fill");
    end
    chk("full.direct", {count, dq.in_ready}, {4'd8, 1'b0});
    // Pop while full: push refused this cycle, accepted the next
    drive(1'b1, rand_inst(), 1'b1);
    tick();
    check_all("full_pop");
    tick();
    check_all("refill");
    drive(1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 9; i++) begin
      tick();
      check_all("drain_wrap");
    end

    // Five entries, then flush with a concurrent push
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b1, rand_inst(), 1'b0);
      tick();
    end
    check_all("pre_flush");
    flush = 1'b1;
    drive(1'b1, rand_inst(), 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check_all("flush");
    chk("flush.direct", {count, dq.out_valid}, {4'd0, 1'b0});

    // Three entries, then freeze with rdy_in low
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, rand_inst(), 1'b0);
      tick();
    end
    rdy = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(i[0], rand_inst(), ~i[0]);
      flush = (i == 2);
      tick();
      check_all("frozen");
    end
    rdy = 1'b1; flush = 1'b0;
    chk("frozen.direct", count, 4'd3);

    // Randomized traffic with phases biased toward filling and draining
    for (int unsigned i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                                          : ($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      tick();
      check_all("rand");
    end
    flush = 1'b0; rdy = 1'b1;

    // Asynchronous reset between clock edges
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, rand_inst(), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #3 rst = 1'b1;
    #1;
    mq.delete();
    mq_m.delete();
    chk("async_rst", {dq.out_valid, count, dq_m.out_valid, count_m, dq.in_ready}, {1'b0, 4'd0, 1'b0, 4'd0, 1'b1});
    check_all("async_rst");
    #2 rst = 1'b0;
    drive(1'b1, 32'h0050_0093, 1'b0);
    tick();
    check_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
